rr_engine_scheduler: RTL and testbench

- Shares one multi-cycle processing engine between NUM_REQ requesters.
- Arbitrates pending requests round-robin and latches the winner's operand. Sequences the engine through an IDLE/START/BUSY/DONE handshake, then returns a completion pulse (and timeout error) to the owning requester.
- Sits between requester-side control logic and the shared engine datapath.

---
 rtl/rr_engine_scheduler.sv | 143 ++++++++++++++
 tb/tb_rr_engine_scheduler.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/rr_engine_scheduler.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | rr_engine_scheduler: round-robin sharing of one multi-cycle engine        |
// | between NUM_REQ requesters. Revision: 1.0                                 |
// +--------------------------------------------------------------------------+
module rr_engine_scheduler #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 8,
  parameter int TIMEOUT = 255
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            req_i,
  input  logic [NUM_REQ*DATA_W-1:0]     req_data_i,
  output logic [NUM_REQ-1:0]            gnt_o,
  output logic [NUM_REQ-1:0]            done_o,
  output logic                          err_o,
  output logic                          eng_start_o,
  output logic [DATA_W-1:0]             eng_data_o,
  input  logic                          eng_done_i,
  output logic                          busy_o,
  output logic [$clog2(NUM_REQ)-1:0]    owner_o
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_REQ - 1);
  localparam logic [IDX_W:0]   REQ_CNT  = (IDX_W + 1)'(NUM_REQ);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_BUSY  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t                 state_q;
  logic [IDX_W-1:0]       rr_ptr_q;
  logic [IDX_W-1:0]       owner_q;
  logic [DATA_W-1:0]      data_q;
  logic [CNT_W-1:0]       cnt_q;
  logic                   err_q;
  logic [NUM_REQ-1:0]     gnt_q;
  logic [NUM_REQ-1:0]     done_q;
  logic                   start_q;

  logic [2*NUM_REQ-1:0]   req_dbl_d;
  logic [NUM_REQ-1:0]     req_rot_d;
  logic                   arb_vld_d;
  logic [IDX_W-1:0]       arb_off_d;
  logic [IDX_W:0]         arb_sum_d;
  logic [IDX_W-1:0]       arb_idx_d;
  logic [DATA_W-1:0]      arb_data_d;

  // Rotate requests so bit 0 is rr_ptr, take the lowest set bit, then undo the rotation.
  always_comb begin
    req_dbl_d = {req_i, req_i};
    req_rot_d = NUM_REQ'(req_dbl_d >> rr_ptr_q);
    arb_vld_d = 1'b0;
    arb_off_d = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req_rot_d[i]) begin
        arb_vld_d = 1'b1;
        arb_off_d = IDX_W'(i);
      end
    end
    arb_sum_d = {1'b0, rr_ptr_q} + {1'b0, arb_off_d};
    if (arb_sum_d >= REQ_CNT) begin
      arb_sum_d = arb_sum_d - REQ_CNT;
    end
    arb_idx_d  = arb_sum_d[IDX_W-1:0];
    arb_data_d = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (arb_idx_d == IDX_W'(i)) begin
        arb_data_d = req_data_i[i*DATA_W +: DATA_W];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      rr_ptr_q <= '0;
      owner_q  <= '0;
      data_q   <= '0;
      cnt_q    <= '0;
      err_q    <= 1'b0;
      gnt_q    <= '0;
      done_q   <= '0;
      start_q  <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (arb_vld_d) begin
            owner_q <= arb_idx_d;
            data_q  <= arb_data_d;
            gnt_q   <= NUM_REQ'(1) << arb_idx_d;
            start_q <= 1'b1;
            state_q <= S_START;
          end
        end
        S_START: begin
          gnt_q   <= '0;
          start_q <= 1'b0;
          cnt_q   <= '0;
          state_q <= S_BUSY;
        end
        S_BUSY: begin
          // A completion in the same cycle as the timeout is reported as success.
          if (eng_done_i) begin
            err_q   <= 1'b0;
            done_q  <= NUM_REQ'(1) << owner_q;
            state_q <= S_DONE;
          end else if ((TIMEOUT != 0) && (cnt_q == CNT_LAST)) begin
            err_q   <= 1'b1;
            done_q  <= NUM_REQ'(1) << owner_q;
            state_q <= S_DONE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        S_DONE: begin
          done_q   <= '0;
          err_q    <= 1'b0;
          rr_ptr_q <= (owner_q == IDX_LAST) ? '0 : owner_q + 1'b1;
          state_q  <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign gnt_o       = gnt_q;
  assign done_o      = done_q;
  assign err_o       = err_q;
  assign eng_start_o = start_q;
  assign eng_data_o  = data_q;
  assign busy_o      = (state_q != S_IDLE);
  assign owner_o     = owner_q;

endmodule
`default_nettype wire

// File: tb/tb_rr_engine_scheduler.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_rr_engine_scheduler: job-level reference model against the scheduler. |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_rr_engine_scheduler;

  localparam int N  = 4;
  localparam int DW = 8;
  localparam int TO = 5;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [N-1:0]    req_i = '0;
  logic [N*DW-1:0] req_data_i = '0;
  logic            eng_done_i = 1'b0;
  logic [N-1:0]    gnt_o;
  logic [N-1:0]    done_o;
  logic            err_o;
  logic            eng_start_o;
  logic [DW-1:0]   eng_data_o;
  logic            busy_o;
  logic [1:0]      owner_o;

  int tests = 0;
  int fails = 0;
  int ptr   = 0;

  rr_engine_scheduler #(.NUM_REQ(N), .DATA_W(DW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .req_i(req_i), .req_data_i(req_data_i),
    .gnt_o(gnt_o), .done_o(done_o), .err_o(err_o), .eng_start_o(eng_start_o),
    .eng_data_o(eng_data_o), .eng_done_i(eng_done_i), .busy_o(busy_o), .owner_o(owner_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Reference arbitration: first set request scanning upward from ptr with wrap.
  function automatic int pick(input logic [3:0] r, input int p);
    for (int k = 0; k < N; k++) begin
      int idx;
      idx = (p + k) % N;
      if (r[idx[1:0]]) return idx;
    end
    return -1;
  endfunction

  // One complete job from an IDLE cycle; d = BUSY cycle index of eng_done_i.
  task automatic job(input logic [3:0] req, input logic [31:0] data, input int d, input bit hold);
    int         w;
    int         kend;
    bit         exp_err;
    logic [7:0] exp_data;
    logic [3:0] oh;
    req_i      = req;
    req_data_i = data;
    @(posedge clk); #1;
    if (req == 4'b0000) begin
      chk("noreq_busy", busy_o, 0);
      chk("noreq_gnt", gnt_o, 0);
      return;
    end
    w        = pick(req, ptr);
    exp_data = 8'(data >> (8 * w));
    oh       = 4'(1 << w);
    chk("gnt", gnt_o, oh);
    chk("start", eng_start_o, 1);
    chk("eng_data", eng_data_o, exp_data);
    chk("owner", owner_o, w);
    chk("start_busy", busy_o, 1);
    chk("start_done", done_o, 0);
    if (!hold) begin
      req_i      = 4'($urandom);
      req_data_i = $urandom;
    end
    exp_err = (d > TO - 1);
    kend    = exp_err ? TO - 1 : d;
    for (int k = 0; k <= kend; k++) begin
      @(posedge clk); #1;
      chk("busy_gnt", gnt_o, 0);
      chk("busy_start", eng_start_o, 0);
      chk("busy_done", done_o, 0);
      chk("busy_hi", busy_o, 1);
      chk("busy_data", eng_data_o, exp_data);
      eng_done_i = (k == d);
    end
    @(posedge clk); #1;
    eng_done_i = 1'b0;
    if (!hold) req_i = '0;
    chk("done", done_o, oh);
    chk("err", err_o, exp_err);
    chk("done_data", eng_data_o, exp_data);
    chk("done_gnt", gnt_o, 0);
    @(posedge clk); #1;
    chk("idle_busy", busy_o, 0);
    chk("idle_done", done_o, 0);
    chk("idle_err", err_o, 0);
    chk("idle_gnt", gnt_o, 0);
    ptr = (w + 1) % N;
    if (exp_err && !hold) begin
      eng_done_i = 1'b1;
      @(posedge clk); #1;
      eng_done_i = 1'b0;
      chk("late_busy", busy_o, 0);
      chk("late_done", done_o, 0);
    end
  endtask

  // Start a job and pull reset asynchronously in the middle of BUSY.
  task automatic abort_job(input logic [3:0] req);
    req_i      = req;
    req_data_i = 32'hC3C3_C3C3;
    @(posedge clk); #1;
    req_i = '0;
    @(posedge clk); #1;
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk("rst_gnt", gnt_o, 0);
    chk("rst_done", done_o, 0);
    chk("rst_err", err_o, 0);
    chk("rst_start", eng_start_o, 0);
    chk("rst_data", eng_data_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_owner", owner_o, 0);
    @(posedge clk); #1;
    chk("rst_hold_done", done_o, 0);
    rst_n = 1'b1;
    ptr   = 0;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("reset_gnt", gnt_o, 0);
    chk("reset_done", done_o, 0);
    chk("reset_err", err_o, 0);
    chk("reset_start", eng_start_o, 0);
    chk("reset_data", eng_data_o, 0);
    chk("reset_busy", busy_o, 0);
    chk("reset_owner", owner_o, 0);
    rst_n = 1'b1;

    repeat (5) job(4'b1111, $urandom, 0, 1'b1);
    req_i = '0;

    job(4'b0100, 32'h00A5_0000, 3, 1'b0);
    job(4'b0001, 32'h1122_3344, 2, 1'b0);
    job(4'b0011, 32'h5566_7788, 1, 1'b0);
    job(4'b1000, 32'hDEAD_BEEF, 50, 1'b0);
    job(4'b0010, 32'h0BAD_F00D, TO - 1, 1'b0);
    job(4'b0100, 32'h1357_9BDF, TO, 1'b0);
    job(4'b0000, 32'h0, 0, 1'b0);

    abort_job(4'b0100);
    job(4'b0010, 32'h0000_5A00, 2, 1'b0);
    abort_job(4'b1000);
    job(4'b0011, 32'h0000_6996, 0, 1'b0);

    repeat (40) job(4'($urandom), $urandom, int'($urandom_range(0, 7)), 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
